// File: rtl/riscv_base_wb_queue_pkg.sv
// Shared register-file widths and the pending-write record used by the writeback queue.
package riscv_base_wb_queue_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]      xlen_t;

   typedef struct packed {
      reg_idx_t rd;
      xlen_t    value;
   } wb_entry_t;

   typedef struct packed {
      logic  hit;
      xlen_t value;
   } byp_res_t;

endpackage

// File: rtl/riscv_base_wb_fifo.sv
// Pending-write storage: up to two pushes (A then B) and one pop per cycle.
// Entries are presented oldest-first with a valid mask so the top can search them.
module riscv_base_wb_fifo
   import riscv_base_wb_queue_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_a_i,
   input  wb_entry_t             push_a_dat_i,
   input  logic                  push_b_i,
   input  wb_entry_t             push_b_dat_i,
   input  logic                  pop_i,
   output wb_entry_t             head_o,
   output logic [CNT_W-1:0]      count_o,
   output wb_entry_t [DEPTH-1:0] ent_o,
   output logic [DEPTH-1:0]      ent_vld_o
);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] b_slot;

   // B lands behind A when both push in the same cycle, keeping A older.
   assign b_slot = push_a_i ? (tail_q + PTR_W'(1)) : tail_q;

   always_comb begin
      head_d  = head_q + PTR_W'(pop_i);
      tail_d  = tail_q + PTR_W'(push_a_i) + PTR_W'(push_b_i);
      count_d = count_q + CNT_W'(push_a_i) + CNT_W'(push_b_i) - CNT_W'(pop_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_a_i) mem_q[tail_q] <= push_a_dat_i;
      if (push_b_i) mem_q[b_slot] <= push_b_dat_i;
   end

   always_comb begin
      ent_o     = '0;
      ent_vld_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_o[i]     = mem_q[head_q + PTR_W'(i)];
         ent_vld_o[i] = (CNT_W'(i) < count_q);
      end
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/riscv_base_wb_queue.sv
// Merges ALU (A) and LSU/MUL (B) results into one ordered regfile write stream,
// with youngest-first bypass of every write not yet committed.
module riscv_base_wb_queue
   import riscv_base_wb_queue_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wb_a_valid_i,
   input  logic [REG_IDX_W-1:0] wb_a_rd_i,
   input  logic [XLEN-1:0]      wb_a_value_i,
   output logic                 wb_a_ready_o,
   input  logic                 wb_b_valid_i,
   input  logic [REG_IDX_W-1:0] wb_b_rd_i,
   input  logic [XLEN-1:0]      wb_b_value_i,
   output logic                 wb_b_ready_o,
   input  logic [REG_IDX_W-1:0] byp_rs1_i,
   input  logic [REG_IDX_W-1:0] byp_rs2_i,
   output logic                 byp_rs1_hit_o,
   output logic [XLEN-1:0]      byp_rs1_value_o,
   output logic                 byp_rs2_hit_o,
   output logic [XLEN-1:0]      byp_rs2_value_o,
   output logic [REG_IDX_W-1:0] rd0_o,
   output logic [XLEN-1:0]      rd0_value_o,
   output logic [CNT_W-1:0]     count_o,
   output logic                 empty_o
);

   localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] B_LIM_C = CNT_W'(DEPTH - 2);

   logic                  a_fire, b_fire, a_push, pop;
   logic [CNT_W-1:0]      count;
   wb_entry_t             head;
   wb_entry_t [DEPTH-1:0] ent;
   logic [DEPTH-1:0]      ent_vld;
   reg_idx_t              rd0_q, rd0_d;
   xlen_t                 rd0_value_q, rd0_value_d;
   byp_res_t              byp1, byp2;

   // Readiness looks only at registered occupancy so producers never see a valid->ready path.
   assign wb_a_ready_o = (count < FULL_C);
   assign wb_b_ready_o = (count <= B_LIM_C);

   assign a_fire = wb_a_valid_i && wb_a_ready_o;
   assign b_fire = wb_b_valid_i && wb_b_ready_o;
   assign a_push = a_fire && (wb_a_rd_i != '0);
   assign pop    = (count != '0);

   riscv_base_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_a_i     (a_push),
      .push_a_dat_i ('{rd: wb_a_rd_i, value: wb_a_value_i}),
      .push_b_i     (b_fire),
      .push_b_dat_i ('{rd: wb_b_rd_i, value: wb_b_value_i}),
      .pop_i        (pop),
      .head_o       (head),
      .count_o      (count),
      .ent_o        (ent),
      .ent_vld_o    (ent_vld)
   );

   always_comb begin
      rd0_d       = '0;
      rd0_value_d = '0;
      if (pop) begin
         rd0_d       = head.rd;
         rd0_value_d = head.value;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd0_q       <= '0;
         rd0_value_q <= '0;
      end else begin
         rd0_q       <= rd0_d;
         rd0_value_q <= rd0_value_d;
      end
   end

   // Later (younger) queue matches overwrite earlier ones; the rd0 stage is the oldest candidate.
   function automatic byp_res_t byp_lookup(
      input reg_idx_t              rs,
      input reg_idx_t              stage_rd,
      input xlen_t                 stage_val,
      input wb_entry_t [DEPTH-1:0] entries,
      input logic [DEPTH-1:0]      vld
   );
      byp_res_t r;
      r = '0;
      if (rs != '0) begin
         if (stage_rd == rs) r = '{hit: 1'b1, value: stage_val};
         for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (entries[i].rd == rs)) r = '{hit: 1'b1, value: entries[i].value};
         end
      end
      return r;
   endfunction

   assign byp1 = byp_lookup(byp_rs1_i, rd0_q, rd0_value_q, ent, ent_vld);
   assign byp2 = byp_lookup(byp_rs2_i, rd0_q, rd0_value_q, ent, ent_vld);

   assign byp_rs1_hit_o   = byp1.hit;
   assign byp_rs1_value_o = byp1.value;
   assign byp_rs2_hit_o   = byp2.hit;
   assign byp_rs2_value_o = byp2.value;

   assign rd0_o       = rd0_q;
   assign rd0_value_o = rd0_value_q;
   assign count_o     = count;
   assign empty_o     = (count == '0) && (rd0_q == '0);

endmodule

// File: tb/tb_riscv_base_wb_queue.sv
// Scoreboard bench: fires are queued in order; a negedge monitor pops on each rd0 write
// and checks occupancy, readiness and bypass against the pending list.
module tb_riscv_base_wb_queue;
   import riscv_base_wb_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk, rst_i;
   logic             wb_a_valid_i, wb_a_ready_o, wb_b_valid_i, wb_b_ready_o;
   logic [4:0]       wb_a_rd_i, wb_b_rd_i, byp_rs1_i, byp_rs2_i, rd0_o;
   logic [31:0]      wb_a_value_i, wb_b_value_i, byp_rs1_value_o, byp_rs2_value_o, rd0_value_o;
   logic             byp_rs1_hit_o, byp_rs2_hit_o, empty_o;
   logic [CNT_W-1:0] count_o;

   riscv_base_wb_queue #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .wb_a_valid_i(wb_a_valid_i), .wb_a_rd_i(wb_a_rd_i), .wb_a_value_i(wb_a_value_i),
      .wb_a_ready_o(wb_a_ready_o),
      .wb_b_valid_i(wb_b_valid_i), .wb_b_rd_i(wb_b_rd_i), .wb_b_value_i(wb_b_value_i),
      .wb_b_ready_o(wb_b_ready_o),
      .byp_rs1_i(byp_rs1_i), .byp_rs2_i(byp_rs2_i),
      .byp_rs1_hit_o(byp_rs1_hit_o), .byp_rs1_value_o(byp_rs1_value_o),
      .byp_rs2_hit_o(byp_rs2_hit_o), .byp_rs2_value_o(byp_rs2_value_o),
      .rd0_o(rd0_o), .rd0_value_o(rd0_value_o), .count_o(count_o), .empty_o(empty_o)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
   } ent_t;

   ent_t        exp_q[$];
   logic [31:0] rf[32];
   logic [31:0] exp_rf[32];
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 0;
   int          max_cnt = 0;
   ent_t        cur_e;
   bit          have_e;
   bit          eh1, eh2;
   logic [31:0] ev1, ev2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
      end
   endtask

   // Pending writes in fire order; the youngest match wins, the entry now at rd0 is oldest.
   function automatic void byp_model(input logic [4:0] rs, output bit hit, output logic [31:0] v);
      hit = 1'b0;
      v   = '0;
      if (rs == 5'd0) return;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].rd == rs) begin
            hit = 1'b1;
            v   = exp_q[i].val;
            return;
         end
      end
      if (have_e && cur_e.rd == rs) begin
         hit = 1'b1;
         v   = cur_e.val;
      end
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         have_e = 1'b0;
         if (rd0_o != 5'd0) begin
            if (exp_q.size() == 0) begin
               chk("rd0_spurious", 32'(rd0_o), 32'd0);
            end else begin
               cur_e  = exp_q.pop_front();
               have_e = 1'b1;
               chk("rd0_idx", 32'(rd0_o), 32'(cur_e.rd));
               chk("rd0_val", rd0_value_o, cur_e.val);
            end
            if (!rst_i) rf[rd0_o] = rd0_value_o;
         end
         chk("count", 32'(count_o), exp_q.size());
         chk("a_ready", 32'(wb_a_ready_o), 32'(exp_q.size() < DEPTH));
         chk("b_ready", 32'(wb_b_ready_o), 32'(exp_q.size() <= DEPTH - 2));
         chk("empty", 32'(empty_o), 32'(exp_q.size() == 0 && !have_e));
         byp_model(byp_rs1_i, eh1, ev1);
         byp_model(byp_rs2_i, eh2, ev2);
         chk("byp1_hit", 32'(byp_rs1_hit_o), 32'(eh1));
         chk("byp1_val", byp_rs1_value_o, ev1);
         chk("byp2_hit", 32'(byp_rs2_hit_o), 32'(eh2));
         chk("byp2_val", byp_rs2_value_o, ev2);
         if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
      end
   end

   // Called at posedge+1; returns at the next posedge+1 after recording what fired.
   task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] aval,
                        input bit bv, input logic [4:0] brd, input logic [31:0] bval,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        output bit fa, output bit fb);
      wb_a_valid_i = av;  wb_a_rd_i = ard;  wb_a_value_i = aval;
      wb_b_valid_i = bv;  wb_b_rd_i = brd;  wb_b_value_i = bval;
      byp_rs1_i    = rs1; byp_rs2_i = rs2;
      fa = av && wb_a_ready_o && !rst_i;
      fb = bv && wb_b_ready_o && !rst_i;
      @(posedge clk);
      if (rst_i) begin
         exp_q.delete();
      end else begin
         if (fa && ard != 5'd0) begin
            exp_q.push_back('{rd: ard, val: aval});
            exp_rf[ard] = aval;
         end
         if (fb) begin
            exp_q.push_back('{rd: brd, val: bval});
            exp_rf[brd] = bval;
         end
      end
      #1;
   endtask

   task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
      bit fa, fb;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rs1, rs2, fa, fb);
   endtask

   task automatic drain(input logic [4:0] rs1, input logic [4:0] rs2);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || rd0_o != 5'd0) && n < 40) begin
         idle(rs1, rs2);
         n++;
      end
      chk("drain_done", 32'(n < 40), 32'd1);
   endtask

   initial begin
      bit          fa, fb;
      int          nxt, it;
      logic [31:0] s10, s11, s12;

      for (int r = 0; r < 32; r++) begin
         rf[r]     = '0;
         exp_rf[r] = '0;
      end
      rst_i = 1'b1;
      wb_a_valid_i = 1'b0; wb_a_rd_i = '0; wb_a_value_i = '0;
      wb_b_valid_i = 1'b0; wb_b_rd_i = '0; wb_b_value_i = '0;
      byp_rs1_i = 5'd1; byp_rs2_i = 5'd2;

      // Reset held three cycles
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      mon_en = 1'b1;
      chk("rst_rd0", 32'(rd0_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_empty", 32'(empty_o), 32'd1);
      chk("rst_a_ready", 32'(wb_a_ready_o), 32'd1);
      chk("rst_b_ready", 32'(wb_b_ready_o), 32'd1);
      chk("rst_hit1", 32'(byp_rs1_hit_o), 32'd0);
      chk("rst_hit2", 32'(byp_rs2_hit_o), 32'd0);

      // Single write, fixed latency
      drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, fa, fb);
      chk("t2_fired", 32'(fa), 32'd1);
      idle(5'd5, 5'd0);
      chk("t2_rd0_idx", 32'(rd0_o), 32'd5);
      chk("t2_rd0_val", rd0_value_o, 32'h1234_5678);
      drain(5'd5, 5'd6);
      chk("t2_x5", rf[5], 32'h1234_5678);

      // Dual fire to the same register, A older than B
      drive(1'b1, 5'd7, 32'hAAAA_0000, 1'b1, 5'd7, 32'hBBBB_0000, 5'd7, 5'd7, fa, fb);
      chk("t3_both_fired", 32'({fa, fb}), 32'd3);
      drain(5'd7, 5'd7);
      chk("t3_x7", rf[7], 32'hBBBB_0000);

      // x0 write is swallowed
      drive(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, fa, fb);
      idle(5'd0, 5'd0);
      chk("t5_count", 32'(count_o), 32'd0);
      chk("t5_rd0", 32'(rd0_o), 32'd0);
      chk("t5_hit", 32'(byp_rs1_hit_o), 32'd0);
      chk("t5_x0", rf[0], 32'd0);

      // Reset with entries pending
      s10 = rf[10]; s11 = rf[11]; s12 = rf[12];
      drive(1'b1, 5'd10, 32'h1010_1010, 1'b1, 5'd11, 32'h1111_1111, 5'd10, 5'd11, fa, fb);
      drive(1'b1, 5'd12, 32'h1212_1212, 1'b0, 5'd0, 32'd0, 5'd12, 5'd10, fa, fb);
      rst_i = 1'b1;
      idle(5'd10, 5'd12);
      rst_i = 1'b0;
      chk("t6_rd0", 32'(rd0_o), 32'd0);
      chk("t6_count", 32'(count_o), 32'd0);
      repeat (3) idle(5'd11, 5'd12);
      chk("t6_x10", rf[10], s10);
      chk("t6_x11", rf[11], s11);
      chk("t6_x12", rf[12], s12);

      // Back-to-back pressure: every register 1..31 once, in order
      nxt = 1;
      it  = 0;
      max_cnt = 0;
      while (nxt <= 31 && it < 200) begin
         drive(1'b1, 5'(nxt), $urandom, (nxt + 1 <= 31), 5'((nxt + 1) % 32), $urandom,
               5'($urandom_range(0, 31)), 5'(nxt), fa, fb);
         nxt += int'(fa) + int'(fb);
         it++;
      end
      chk("t4_all_fired", 32'(nxt > 31), 32'd1);
      drain(5'd0, 5'd0);
      chk("t4_peak", 32'(max_cnt >= DEPTH - 1), 32'd1);
      for (int r = 1; r < 32; r++) chk("t4_rf", rf[r], exp_rf[r]);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)), fa, fb);
      end
      drain(5'd3, 5'd0);
      for (int r = 1; r < 32; r++) chk("rand_rf", rf[r], exp_rf[r]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
